// File: rtl/ser_tx_lsb.sv
// LSB-first parallel-to-serial transmitter with one-word holding register and sof/eof strobes.
// Optional even-parity bit after each word when SER_TX_PARITY_EN is defined.
module ser_tx_lsb #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned GAP   = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             ser_sof,
    output logic             ser_eof,
    output logic             busy
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LastBit = CW'(WIDTH - 1);
    localparam logic [3:0] GapLast = 4'((GAP == 0) ? 0 : GAP - 1);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StShift = 2'd1,
        StGap   = 2'd2
`ifdef SER_TX_PARITY_EN
        , StPar = 2'd3
`endif
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic             hold_full_q, hold_full_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [3:0]       gap_cnt_q, gap_cnt_d;
    logic             ser_out_q, ser_out_d;
    logic             ser_valid_q, ser_valid_d;
    logic             ser_sof_q, ser_sof_d;
    logic             ser_eof_q, ser_eof_d;
    logic             busy_q, busy_d;
`ifdef SER_TX_PARITY_EN
    logic             par_q, par_d;
`endif

    logic accept;
    logic load;
    logic end_frame;

    assign in_ready = ~hold_full_q;
    assign accept   = in_valid & ~hold_full_q;

    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        shreg_d     = shreg_q;
        cnt_d       = cnt_q;
        gap_cnt_d   = gap_cnt_q;
`ifdef SER_TX_PARITY_EN
        par_d       = par_q;
`endif
        load        = 1'b0;
        end_frame   = 1'b0;

        case (state_q)
            StIdle: begin
                if (hold_full_q) load = 1'b1;
            end
            StShift: begin
                if (cnt_q == LastBit) begin
`ifdef SER_TX_PARITY_EN
                    state_d = StPar;
`else
                    end_frame = 1'b1;
`endif
                end else begin
                    shreg_d = shreg_q >> 1;
                    cnt_d   = cnt_q + CW'(1);
                end
            end
`ifdef SER_TX_PARITY_EN
            StPar: begin
                end_frame = 1'b1;
            end
`endif
            StGap: begin
                if (gap_cnt_q == GapLast) begin
                    if (hold_full_q) load = 1'b1;
                    else             state_d = StIdle;
                end else begin
                    gap_cnt_d = gap_cnt_q + 4'd1;
                end
            end
            default: state_d = StIdle;
        endcase

        if (end_frame) begin
            if (GAP > 0) begin
                state_d   = StGap;
                gap_cnt_d = 4'd0;
            end else if (hold_full_q) begin
                load = 1'b1;
            end else begin
                state_d = StIdle;
            end
        end

        if (load) begin
            state_d     = StShift;
            shreg_d     = hold_q;
            cnt_d       = '0;
            hold_full_d = 1'b0;
`ifdef SER_TX_PARITY_EN
            par_d       = ^hold_q;
`endif
        end

        // A write in the same cycle as a reload keeps the register full.
        if (accept) begin
            hold_d      = in_data;
            hold_full_d = 1'b1;
        end

        // Outputs are registered from the next state so they line up with it.
        ser_valid_d = (state_d == StShift);
        ser_out_d   = (state_d == StShift) & shreg_d[0];
        ser_sof_d   = (state_d == StShift) && (cnt_d == '0);
`ifdef SER_TX_PARITY_EN
        ser_valid_d = ser_valid_d | (state_d == StPar);
        ser_out_d   = ser_out_d | ((state_d == StPar) & par_d);
        ser_eof_d   = (state_d == StPar);
`else
        ser_eof_d   = (state_d == StShift) && (cnt_d == LastBit);
`endif
        busy_d      = (state_d != StIdle) | hold_full_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            shreg_q     <= '0;
            cnt_q       <= '0;
            gap_cnt_q   <= '0;
            ser_out_q   <= 1'b0;
            ser_valid_q <= 1'b0;
            ser_sof_q   <= 1'b0;
            ser_eof_q   <= 1'b0;
            busy_q      <= 1'b0;
`ifdef SER_TX_PARITY_EN
            par_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            shreg_q     <= shreg_d;
            cnt_q       <= cnt_d;
            gap_cnt_q   <= gap_cnt_d;
            ser_out_q   <= ser_out_d;
            ser_valid_q <= ser_valid_d;
            ser_sof_q   <= ser_sof_d;
            ser_eof_q   <= ser_eof_d;
            busy_q      <= busy_d;
`ifdef SER_TX_PARITY_EN
            par_q       <= par_d;
`endif
        end
    end

    assign ser_out   = ser_out_q;
    assign ser_valid = ser_valid_q;
    assign ser_sof   = ser_sof_q;
    assign ser_eof   = ser_eof_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_ser_tx_lsb.sv
// Scoreboard bench for ser_tx_lsb: one instance with GAP=0 and one with GAP=2.
module tb_ser_tx_lsb;

    localparam int W = 8;
`ifdef SER_TX_PARITY_EN
    localparam int FLEN = W + 1;
`else
    localparam int FLEN = W;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] in_data0, in_data1;
    logic         in_valid0, in_valid1;
    logic         in_ready0, in_ready1;
    logic         ser_out0, ser_valid0, ser_sof0, ser_eof0, busy0;
    logic         ser_out1, ser_valid1, ser_sof1, ser_eof1, busy1;

    always #5 clk = ~clk;

    ser_tx_lsb #(.WIDTH(W), .GAP(0)) dut0 (
        .clk(clk), .rst(rst), .in_data(in_data0), .in_valid(in_valid0), .in_ready(in_ready0),
        .ser_out(ser_out0), .ser_valid(ser_valid0), .ser_sof(ser_sof0), .ser_eof(ser_eof0),
        .busy(busy0)
    );

    ser_tx_lsb #(.WIDTH(W), .GAP(2)) dut1 (
        .clk(clk), .rst(rst), .in_data(in_data1), .in_valid(in_valid1), .in_ready(in_ready1),
        .ser_out(ser_out1), .ser_valid(ser_valid1), .ser_sof(ser_sof1), .ser_eof(ser_eof1),
        .busy(busy1)
    );

    int n_checks = 0;
    int n_pass   = 0;

    logic [W-1:0] exp0[$];
    logic [W-1:0] exp1[$];
    int           gap0[$];
    int           gap1[$];

    bit           inframe[2];
    int           bitidx[2];
    logic [W-1:0] word[2];
    logic         parbit[2];
    int           idle_run[2];
    bit           have_prev[2];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] expv);
        n_checks++;
        if (got === expv) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, got, expv, $time);
    endtask

    // Rebuilds each frame from the serial stream and compares it with the queued word.
    task automatic mon_step(input int s, input logic v, input logic o, input logic sof,
                            input logic eof);
        logic [W-1:0] e;
        int           qs;
        if (rst) begin
            inframe[s]  = 1'b0;
            idle_run[s] = 0;
            return;
        end
        if (!v) begin
            check($sformatf("d%0d_idle_out", s), o, 1'b0);
            if (inframe[s]) check($sformatf("d%0d_frame_cont", s), v, 1'b1);
            inframe[s] = 1'b0;
            idle_run[s]++;
            return;
        end
        if (!inframe[s]) begin
            check($sformatf("d%0d_sof", s), sof, 1'b1);
            if (have_prev[s]) begin
                if (s == 0) gap0.push_back(idle_run[s]);
                else        gap1.push_back(idle_run[s]);
            end
            inframe[s] = 1'b1;
            bitidx[s]  = 0;
            word[s]    = '0;
        end else begin
            check($sformatf("d%0d_sof_mid", s), sof, 1'b0);
        end
        if (bitidx[s] < W) word[s][bitidx[s]] = o;
        else               parbit[s] = o;
        check($sformatf("d%0d_eof_b%0d", s, bitidx[s]), eof, (bitidx[s] == FLEN - 1));
        if (bitidx[s] == FLEN - 1) begin
            qs = (s == 0) ? exp0.size() : exp1.size();
            if (qs == 0) begin
                check($sformatf("d%0d_unexpected_frame", s), qs, 1);
            end else begin
                if (s == 0) e = exp0.pop_front();
                else        e = exp1.pop_front();
                check($sformatf("d%0d_word", s), word[s], e);
`ifdef SER_TX_PARITY_EN
                check($sformatf("d%0d_parity", s), parbit[s], ^e);
`endif
            end
            inframe[s]   = 1'b0;
            have_prev[s] = 1'b1;
            idle_run[s]  = 0;
        end else begin
            bitidx[s]++;
        end
    endtask

    always @(negedge clk) begin
        mon_step(0, ser_valid0, ser_out0, ser_sof0, ser_eof0);
        mon_step(1, ser_valid1, ser_out1, ser_sof1, ser_eof1);
    end

    task automatic send(input int s, input logic [W-1:0] d, input bit keep);
        bit acc;
        acc = 1'b0;
        for (int i = 0; i < 100 && !acc; i++) begin
            @(negedge clk);
            if (s == 0) begin
                in_data0 = d; in_valid0 = 1'b1; acc = in_ready0;
            end else begin
                in_data1 = d; in_valid1 = 1'b1; acc = in_ready1;
            end
            @(posedge clk);
            if (acc) begin
                if (s == 0) exp0.push_back(d);
                else        exp1.push_back(d);
            end
        end
        if (!acc) check("send_timeout", acc, 1'b1);
        if (!keep) begin
            #1;
            if (s == 0) in_valid0 = 1'b0;
            else        in_valid1 = 1'b0;
        end
    endtask

    task automatic wait_idle(input int s);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 400 && !done; i++) begin
            @(negedge clk);
            if (s == 0) done = (exp0.size() == 0) && !busy0;
            else        done = (exp1.size() == 0) && !busy1;
        end
        check($sformatf("d%0d_drain", s), done, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit acc;
        rst = 1'b1;
        in_data0 = '0; in_valid0 = 1'b0;
        in_data1 = '0; in_valid1 = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_valid", ser_valid0, 1'b0);
        check("rst_out", ser_out0, 1'b0);
        check("rst_sof", ser_sof0, 1'b0);
        check("rst_eof", ser_eof0, 1'b0);
        check("rst_busy", busy0, 1'b0);
        check("rst_ready", in_ready0, 1'b1);
        check("rst_ready1", in_ready1, 1'b1);
        @(negedge clk);
        rst = 1'b0;

        // Single frame with exact latency.
        @(negedge clk);
        in_data0 = 8'hB4; in_valid0 = 1'b1;
        check("t1_ready", in_ready0, 1'b1);
        @(posedge clk);
        exp0.push_back(8'hB4);
        #1 in_valid0 = 1'b0;
        check("t1_not_yet", ser_valid0, 1'b0);
        check("t1_busy_held", busy0, 1'b1);
        check("t1_ready_full", in_ready0, 1'b0);
        @(posedge clk);
        #1;
        check("t1_first_valid", ser_valid0, 1'b1);
        check("t1_first_sof", ser_sof0, 1'b1);
        check("t1_bit0", ser_out0, 1'b0);
        wait_idle(0);
        check("t1_end_valid", ser_valid0, 1'b0);
        check("t1_end_busy", busy0, 1'b0);
        check("t1_end_ready", in_ready0, 1'b1);

        // Odd-weight word (parity 1 when enabled).
        send(0, 8'h07, 1'b0);
        wait_idle(0);

        // Back-to-back frames with GAP=0.
        gap0.delete();
        have_prev[0] = 1'b0;
        send(0, 8'h01, 1'b1);
        send(0, 8'h80, 1'b1);
        #2 check("t2_ready_low", in_ready0, 1'b0);
        send(0, 8'hFF, 1'b0);
        wait_idle(0);
        check("t2_gap_count", gap0.size(), 2);
        if (gap0.size() == 2) begin
            check("t2_gap_a", gap0[0], 0);
            check("t2_gap_b", gap0[1], 0);
        end

        // Two idle cycles between frames with GAP=2.
        gap1.delete();
        have_prev[1] = 1'b0;
        send(1, 8'h5A, 1'b0);
        send(1, 8'hC3, 1'b0);
        wait_idle(1);
        check("t3_gap_count", gap1.size(), 1);
        if (gap1.size() == 1) check("t3_gap", gap1[0], 2);

        // Data changing while in_ready is low: only the accepted value goes out.
        send(0, 8'h11, 1'b0);
        send(0, 8'h22, 1'b0);
        acc = 1'b0;
        for (int i = 0; i < 40 && !acc; i++) begin
            @(negedge clk);
            in_data0 = 8'h40 + 8'(i);
            in_valid0 = 1'b1;
            acc = in_ready0;
            @(posedge clk);
            if (acc) exp0.push_back(8'h40 + 8'(i));
        end
        #1 in_valid0 = 1'b0;
        check("t6_accepted", acc, 1'b1);
        wait_idle(0);

        // Reset mid-frame with a queued word.
        send(0, 8'hFF, 1'b0);
        send(0, 8'h0F, 1'b0);
        repeat (2) @(posedge clk);
        #2;
        check("t4_mid_frame", ser_valid0, 1'b1);
        rst = 1'b1;
        #1;
        check("t4_rst_valid", ser_valid0, 1'b0);
        check("t4_rst_ready", in_ready0, 1'b1);
        check("t4_rst_busy", busy0, 1'b0);
        exp0.delete();
        exp1.delete();
        have_prev[0] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("t4_quiet", ser_valid0, 1'b0);
        send(0, 8'h3C, 1'b0);
        wait_idle(0);

        check("left0", exp0.size(), 0);
        check("left1", exp1.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
